// File: rtl/frame_buf_if.sv
// Renderer/display-side bus of the double-buffered frame store: pixel writes,
// the swap_req/swap_ack handshake, and the dspl_ctrl read port.
interface frame_buf_if #(
    parameter int DATA_W    = 12,
    parameter int RD_ADDR_W = 10
);
    logic                 wr_en;
    logic [RD_ADDR_W:0]   wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 swap_req;
    logic                 swap_ack;
    logic                 wr_drop;
    logic                 front;
    logic [RD_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]    din_top;
    logic [DATA_W-1:0]    din_btm;

    modport master (
        output wr_en, wr_addr, wr_data, swap_req, r_addr,
        input  swap_ack, wr_drop, front, din_top, din_btm
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, swap_req, r_addr,
        output swap_ack, wr_drop, front, din_top, din_btm
    );
endinterface

// File: rtl/frame_buf.sv
// Two-bank RGB444 frame store. Reads have 1-cycle latency from the front bank.
// A swap waits for a display frame wrap. Writes arriving while a swap is pending are dropped and flagged.
module frame_buf #(
    parameter int DATA_W    = 12,
    parameter int RD_ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    frame_buf_if.slave     bus
);
    localparam int DEPTH = 1 << RD_ADDR_W;

    typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

    state_t               state, state_nxt;
    logic                 front_q;
    logic                 toggle;
    logic                 swap_ack_q;
    logic                 wr_drop_q;
    logic [3:0]           prev_row;
    logic                 frame_wrap;
    logic                 wr_ok;
    logic [DATA_W-1:0]    din_top_q, din_btm_q;

    // Index is {bank, word}; the top and bottom halves live in separate arrays
    // so both can be read every cycle alongside one write.
    logic [DATA_W-1:0]    ram_top [0:2*DEPTH-1];
    logic [DATA_W-1:0]    ram_btm [0:2*DEPTH-1];

    assign frame_wrap = (prev_row == 4'hF) && (bus.r_addr[RD_ADDR_W-1 -: 4] == 4'h0);
    assign wr_ok      = bus.wr_en && (state != PEND);

    always_comb begin
        state_nxt = state;
        toggle    = 1'b0;
        case (state)
            IDLE: if (bus.swap_req) state_nxt = PEND;
            PEND: if (frame_wrap) begin
                      state_nxt = ACK;
                      toggle    = 1'b1;
                  end
            ACK:  if (!bus.swap_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            front_q    <= 1'b0;
            swap_ack_q <= 1'b0;
            wr_drop_q  <= 1'b0;
            prev_row   <= 4'h0;
            din_top_q  <= '0;
            din_btm_q  <= '0;
        end else begin
            state      <= state_nxt;
            front_q    <= front_q ^ toggle;
            swap_ack_q <= (state_nxt == ACK);
            wr_drop_q  <= bus.wr_en && (state == PEND);
            prev_row   <= bus.r_addr[RD_ADDR_W-1 -: 4];
            // Old front is used on the swap edge; the new bank is seen from the next read on.
            din_top_q  <= ram_top[{front_q, bus.r_addr}];
            din_btm_q  <= ram_btm[{front_q, bus.r_addr}];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (bus.wr_addr[RD_ADDR_W])
                ram_btm[{~front_q, bus.wr_addr[RD_ADDR_W-1:0]}] <= bus.wr_data;
            else
                ram_top[{~front_q, bus.wr_addr[RD_ADDR_W-1:0]}] <= bus.wr_data;
        end
    end

    assign bus.front    = front_q;
    assign bus.swap_ack = swap_ack_q;
    assign bus.wr_drop  = wr_drop_q;
    assign bus.din_top  = din_top_q;
    assign bus.din_btm  = din_btm_q;
endmodule
